mem_access_unit: RTL and testbench

//  MEM-stage data-memory sequencer. Accepts one load/store per handshake from EX/MEM.

---
 rtl/mem_access_unit.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory sequencer: one load/store in flight, wait-state memory port, timeout, raw-word response.
// Optional misalignment trap is compiled in when MEM_ALIGN_CHECK_EN is defined.
module mem_access_unit #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_ls_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_word,
  output logic [2:0]  rsp_load_type,
  output logic [1:0]  rsp_addr_lo,
  output logic        rsp_is_store,
  output logic        rsp_err_bus,
  output logic        rsp_err_align,
  output logic [1:0]  o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid and its fields stay stable until then, ready never waits on valid.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam bit              TIMEOUT_EN = (MAX_WAIT != 0);
  localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(MAX_WAIT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req_ready;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [3:0]       r_mem_be;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_word;
  logic [2:0]       r_rsp_load_type;
  logic [1:0]       r_rsp_addr_lo;
  logic             r_rsp_is_store;
  logic             r_rsp_err_bus;

  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic             w_accept;

  assign w_accept = req_valid && r_req_ready;

  // Lane decode; ls_type 5..7 falls through to word.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = req_wdata;
    case (req_ls_type)
      3'd0, 3'd1: begin
        w_be    = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      3'd2, 3'd3: begin
        w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!req_is_store) w_wdata = '0;
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic w_misalign;
  logic r_rsp_err_align;

  always_comb begin
    case (req_ls_type)
      3'd0, 3'd1: w_misalign = 1'b0;
      3'd2, 3'd3: w_misalign = req_addr[0];
      default:    w_misalign = |req_addr[1:0];
    endcase
  end

  assign rsp_err_align = r_rsp_err_align;
`else
  assign rsp_err_align = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_req_ready     <= 1'b1;
      r_mem_req       <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_be        <= '0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_rsp_valid     <= 1'b0;
      r_rsp_word      <= '0;
      r_rsp_load_type <= '0;
      r_rsp_addr_lo   <= '0;
      r_rsp_is_store  <= 1'b0;
      r_rsp_err_bus   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      r_rsp_err_align <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_ready     <= 1'b0;
            r_rsp_load_type <= req_ls_type;
            r_rsp_addr_lo   <= req_addr[1:0];
            r_rsp_is_store  <= req_is_store;
            r_rsp_word      <= '0;
            r_rsp_err_bus   <= 1'b0;
            r_mem_be        <= w_be;
            r_mem_addr      <= {req_addr[31:2], 2'b00};
            r_mem_wdata     <= w_wdata;
            r_cnt           <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            r_rsp_err_align <= w_misalign;
            if (w_misalign) begin
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_mem_req <= 1'b1;
              r_mem_we  <= req_is_store;
              r_state   <= S_ACCESS;
            end
`else
            r_mem_req <= 1'b1;
            r_mem_we  <= req_is_store;
            r_state   <= S_ACCESS;
`endif
          end
        end
        S_ACCESS: begin
          // An ack on the limit cycle still completes normally.
          if (mem_ack) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_word  <= r_rsp_is_store ? 32'h0 : mem_rdata;
            r_state     <= S_RESP;
          end else if (TIMEOUT_EN && (r_cnt == LIMIT)) begin
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_word    <= '0;
            r_rsp_err_bus <= 1'b1;
            r_state       <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_mem_req   <= 1'b0;
          r_mem_we    <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign mem_req       = r_mem_req;
  assign mem_we        = r_mem_we;
  assign mem_be        = r_mem_be;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_word      = r_rsp_word;
  assign rsp_load_type = r_rsp_load_type;
  assign rsp_addr_lo   = r_rsp_addr_lo;
  assign rsp_is_store  = r_rsp_is_store;
  assign rsp_err_bus   = r_rsp_err_bus;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed timing cases plus randomized traffic against a queue-based reference model.
module tb_mem_access_unit;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_ls_type;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_word;
  logic [2:0]  rsp_load_type;
  logic [1:0]  rsp_addr_lo;
  logic        rsp_is_store, rsp_err_bus, rsp_err_align;
  logic [1:0]  o_dbg_state;

  mem_access_unit #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_ls_type(req_ls_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_word(rsp_word),
    .rsp_load_type(rsp_load_type), .rsp_addr_lo(rsp_addr_lo), .rsp_is_store(rsp_is_store),
    .rsp_err_bus(rsp_err_bus), .rsp_err_align(rsp_err_align), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [68:0] mem_exp_q[$];  // {we, be, addr, wdata (stores only)}
  logic [39:0] rsp_exp_q[$];  // {word, type, addr_lo, is_store, err_bus, err_align}

  int          cur_ack_delay = 0;
  int          cur_rsp_delay = 0;
  logic [31:0] cur_rdata     = '0;
  logic        idle_ready    = 1'b0;
  logic        stale_ack     = 1'b0;

  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: expected event did not occur", name);
  endtask

  // ---------------- memory and downstream responders ----------------
  initial begin
    int wait_cnt;
    int rcnt;
    wait_cnt  = 0;
    rcnt      = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack   = stale_ack;
      mem_rdata = $urandom;
      if (mem_req) begin
        if (wait_cnt == cur_ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = cur_rdata;
        end
        wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
      if (rsp_valid) begin
        rsp_ready = (rcnt >= cur_rsp_delay);
        rcnt++;
      end else begin
        rsp_ready = idle_ready;
        rcnt      = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [68:0] mem_hold;
  logic [39:0] rsp_hold;
  logic        mem_was = 1'b0;
  logic        rsp_was = 1'b0;
  logic        hs_prev = 1'b0;

  always @(negedge clk) begin
    logic [68:0] mcur;
    logic [39:0] rcur;
    if (!rst_n) begin
      mem_was = 1'b0;
      rsp_was = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) chk("idle_after_hs", {66'd0, req_ready, o_dbg_state}, {66'd0, 1'b1, 2'd0});
      hs_prev = 1'b0;
      mcur = {mem_we, mem_be, mem_addr, mem_we ? mem_wdata : 32'h0};
      if (mem_req) begin
        if (mem_was) chk("mem_stable", mcur, mem_hold);
        else if (mem_exp_q.size() == 0) note_fail("mem_unexpected");
        else chk("mem_fields", mcur, mem_exp_q.pop_front());
        mem_hold = mcur;
      end
      mem_was = mem_req;
      rcur = {rsp_word, rsp_load_type, rsp_addr_lo, rsp_is_store, rsp_err_bus, rsp_err_align};
      if (rsp_valid) begin
        if (rsp_was) chk("rsp_stable", {29'd0, rcur}, {29'd0, rsp_hold});
        rsp_hold = rcur;
        if (rsp_ready) begin
          if (rsp_exp_q.size() == 0) note_fail("rsp_unexpected");
          else chk("rsp_fields", {29'd0, rcur}, {29'd0, rsp_exp_q.pop_front()});
          hs_prev = 1'b1;
        end
      end
      rsp_was = rsp_valid && !rsp_ready;
    end
  end

  // ---------------- driver with reference model ----------------
  task automatic issue(input logic st, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int ack_d, input int rsp_d);
    int          size;
    int          off;
    int          guard;
    logic [3:0]  be;
    logic [31:0] rep;
    logic        mis;
    logic        eb;
    logic [31:0] word;
    size = (t <= 3'd1) ? 1 : (t <= 3'd3) ? 2 : 4;
    off  = int'(a[1:0]) & ~(size - 1);
    be   = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) rep[8*i +: 8] = wd[8*(i % size) +: 8];
`ifdef MEM_ALIGN_CHECK_EN
    mis = (int'(a[1:0]) % size) != 0;
`else
    mis = 1'b0;
`endif
    eb   = !mis && (MAX_WAIT != 0) && (ack_d >= MAX_WAIT);
    word = (st || mis || eb) ? 32'h0 : rd;
    guard = 0;
    while (!req_ready) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 500) begin
        note_fail("accept_timeout");
        return;
      end
    end
    cur_ack_delay = ack_d;
    cur_rsp_delay = rsp_d;
    cur_rdata     = rd;
    if (!mis) mem_exp_q.push_back({st, be, a[31:2], 2'b00, st ? rep : 32'h0});
    rsp_exp_q.push_back({word, t, a[1:0], st, eb, mis});
    req_valid    = 1'b1;
    req_is_store = st;
    req_ls_type  = t;
    req_addr     = a;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!(req_ready && !rsp_valid && rsp_exp_q.size() == 0 && mem_exp_q.size() == 0)) begin
      @(negedge clk);
      guard++;
      if (guard > 500) begin
        note_fail("idle_timeout");
        return;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt;
    logic st;
    logic [2:0] t;
    req_valid = 1'b0; req_is_store = 1'b0; req_ls_type = '0; req_addr = '0; req_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_state",
        {req_ready, mem_req, mem_we, mem_be, rsp_valid, rsp_err_bus, rsp_err_align, o_dbg_state, mem_addr, rsp_word, 26'd0},
        {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 26'd0});

    // LW, zero wait: mem_req at T+1, rsp_valid at T+2
    issue(1'b0, 3'd4, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0);
    @(negedge clk);
    chk("lw_t1", {63'd0, mem_req, rsp_valid, mem_be}, {63'd0, 1'b1, 1'b0, 4'b1111});
    @(negedge clk);
    chk("lw_t2", {67'd0, mem_req, rsp_valid}, {67'd0, 1'b0, 1'b1});
    wait_idle();

    // SB to lane 3
    issue(1'b1, 3'd0, 32'h0000_0203, 32'h0000_00A5, 32'h1111_1111, 1, 0);
    wait_idle();

    // SH with 3 wait cycles: req_ready low for 5 cycles
    issue(1'b1, 3'd2, 32'h0000_0302, 32'h0000_1234, 32'h0, 3, 0);
    cnt = 1;
    @(negedge clk);
    while (!req_ready && cnt < 50) begin
      @(negedge clk);
      if (!req_ready) cnt++;
    end
    chk("sh_busy_cycles", 69'(cnt), 69'd5);
    wait_idle();

    // LB with a stalled downstream
    issue(1'b0, 3'd0, 32'h0000_0401, 32'h0, 32'hCAFE_F00D, 0, 4);
    wait_idle();

    // No ack: mem_req high for MAX_WAIT cycles, then bus error
    issue(1'b0, 3'd4, 32'h0000_0500, 32'h0, 32'h5555_AAAA, 100, 0);
    cnt = 0;
    @(negedge clk);
    while (mem_req && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("timeout_req_cycles", 69'(cnt), 69'(MAX_WAIT));
    wait_idle();

    // Ack on the limit cycle wins
    issue(1'b0, 3'd4, 32'h0000_0504, 32'h0, 32'h0BAD_CAFE, MAX_WAIT - 1, 0);
    wait_idle();

    // Misaligned word
    issue(1'b0, 3'd4, 32'h0000_0102, 32'h0, 32'h7777_8888, 0, 0);
    @(negedge clk);
`ifdef MEM_ALIGN_CHECK_EN
    chk("align_t1", {66'd0, rsp_valid, mem_req, rsp_err_align}, {66'd0, 1'b1, 1'b0, 1'b1});
`else
    chk("noalign_t1", {64'd0, mem_req, mem_be}, {64'd0, 1'b1, 4'b1111});
`endif
    wait_idle();

    // Reset while in ACCESS
    issue(1'b0, 3'd4, 32'h0000_0600, 32'h0, 32'h0, 100, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_in_access", {66'd0, mem_req, req_ready, rsp_valid}, {66'd0, 1'b0, 1'b1, 1'b0});
    rst_n = 1'b1;
    void'(rsp_exp_q.pop_back());
    cur_ack_delay = 0;

    // Stale ack in IDLE is ignored
    @(posedge clk);
    #1;
    stale_ack = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    stale_ack = 1'b0;
    @(negedge clk);
    chk("stale_ack", {64'd0, req_ready, rsp_valid, mem_req, o_dbg_state}, {64'd0, 1'b1, 1'b0, 1'b0, 2'd0});

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      st = 1'($urandom_range(0, 1));
      if (st) t = 3'($urandom_range(0, 2) * 2);
      else    t = 3'($urandom_range(0, 7));
      idle_ready = 1'($urandom_range(0, 1));
      issue(st, t, $urandom, $urandom, $urandom,
            ($urandom_range(0, 7) == 0) ? 6 : int'($urandom_range(0, 4)),
            int'($urandom_range(0, 3)));
    end
    wait_idle();
    chk("queues_drained", 69'(mem_exp_q.size() + rsp_exp_q.size()), 69'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
